mux_scan_seq: RTL and testbench



---
 rtl/mux_scan_seq_if.sv | 17 +
 rtl/mux_scan_seq.sv | 132 +++++++++++++
 tb/tb_mux_scan_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_seq_if.sv
// Output stream of mux_scan_seq: registered word, its index, valid/last flags
// and the downstream ready.
interface mux_scan_seq_if #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 64
);
  localparam int SEL_W = $clog2(N_IN);

  logic [DATA_W-1:0] Out_Data;
  logic              Out_Valid;
  logic              Out_Last;
  logic [SEL_W-1:0]  Out_Idx;
  logic              Out_Ready;

  modport master (output Out_Data, Out_Valid, Out_Last, Out_Idx, input Out_Ready);
  modport slave  (input Out_Data, Out_Valid, Out_Last, Out_Idx, output Out_Ready);
endinterface

// File: rtl/mux_scan_seq.sv
// Strided scan over a packed bank of words: emits Len words starting at Base,
// stepping by Stride modulo N_IN, one word per cycle under a valid/ready handshake.
module mux_scan_seq #(
  parameter  int DATA_W = 16,
  parameter  int N_IN   = 64,
  localparam int SEL_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*DATA_W-1:0] Reg_Outs,
  input  logic                   Start,
  input  logic [SEL_W-1:0]       Base,
  input  logic [SEL_W-1:0]       Stride,
  input  logic [SEL_W:0]         Len,
  input  logic                   Abort,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Err,
  mux_scan_seq_if.master         out_if
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_IN);
  localparam logic [SEL_W:0] ONE   = (SEL_W+1)'(1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  idx_q, stride_q;
  logic [SEL_W:0]    remain_q;       // words still to emit after the current one
  logic              valid_q, last_q, done_q, err_q;

  logic [DATA_W-1:0] words [N_IN];
  logic [SEL_W:0]    idx_sum, idx_wrap;
  logic [SEL_W-1:0]  idx_next;
  logic              params_ok, handshake;
  logic              load_first, load_next, clear, done_d, err_d;

  always_comb begin
    for (int i = 0; i < N_IN; i++) words[i] = Reg_Outs[i*DATA_W +: DATA_W];
  end

  // Both operands are below N_IN, so a single conditional subtract wraps the sum.
  assign idx_sum   = {1'b0, idx_q} + {1'b0, stride_q};
  assign idx_wrap  = idx_sum - N_LIM;
  assign idx_next  = (idx_sum >= N_LIM) ? idx_wrap[SEL_W-1:0] : idx_sum[SEL_W-1:0];
  assign params_ok = ({1'b0, Base} < N_LIM) && ({1'b0, Stride} < N_LIM) && (Len <= N_LIM);
  assign handshake = valid_q && out_if.Out_Ready;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    load_next  = 1'b0;
    clear      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          if (!params_ok) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (Len == '0) begin
            done_d = 1'b1;
          end else begin
            load_first = 1'b1;
            state_d    = SCAN;
          end
        end
      end
      SCAN: begin
        if (Abort || (handshake && last_q)) begin
          clear   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (handshake) begin
          load_next = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the datapath registers are reset too, because the outputs must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      idx_q    <= '0;
      stride_q <= '0;
      remain_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (load_first) begin
        data_q   <= words[Base];
        idx_q    <= Base;
        stride_q <= Stride;
        remain_q <= Len - ONE;
        valid_q  <= 1'b1;
        last_q   <= (Len == ONE);
      end else if (load_next) begin
        data_q   <= words[idx_next];
        idx_q    <= idx_next;
        remain_q <= remain_q - ONE;
        last_q   <= (remain_q == ONE);
      end else if (clear) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign Busy             = (state_q == SCAN);
  assign Done             = done_q;
  assign Err              = err_q;
  assign out_if.Out_Data  = data_q;
  assign out_if.Out_Idx   = idx_q;
  assign out_if.Out_Valid = valid_q;
  assign out_if.Out_Last  = last_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Randomized and directed bench for mux_scan_seq; two instances (N_IN=64 and 48)
// share the word bank and scan parameters, each has its own Start and Out_Ready.
module tb_mux_scan_seq;
  localparam int DATA_W = 16;
  localparam int N_A    = 64;
  localparam int N_B    = 48;
  localparam int SEL_W  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [DATA_W-1:0]      tbl [N_A];
  logic [N_A*DATA_W-1:0]  reg_outs;
  logic [1:0]             start;
  logic [SEL_W-1:0]       base, stride;
  logic [SEL_W:0]         len;
  logic                   abort;
  logic                   busy_a, done_a, err_a, busy_b, done_b, err_b;

  always_comb begin
    for (int i = 0; i < N_A; i++) reg_outs[i*DATA_W +: DATA_W] = tbl[i];
  end

  mux_scan_seq_if #(.DATA_W(DATA_W), .N_IN(N_A)) if_a ();
  mux_scan_seq_if #(.DATA_W(DATA_W), .N_IN(N_B)) if_b ();

  mux_scan_seq #(.DATA_W(DATA_W), .N_IN(N_A)) u_a (
    .clk(clk), .rst_n(rst_n), .Reg_Outs(reg_outs), .Start(start[0]),
    .Base(base), .Stride(stride), .Len(len), .Abort(abort),
    .Busy(busy_a), .Done(done_a), .Err(err_a), .out_if(if_a.master));

  mux_scan_seq #(.DATA_W(DATA_W), .N_IN(N_B)) u_b (
    .clk(clk), .rst_n(rst_n), .Reg_Outs(reg_outs[N_B*DATA_W-1:0]), .Start(start[1]),
    .Base(base), .Stride(stride), .Len(len), .Abort(abort),
    .Busy(busy_b), .Done(done_b), .Err(err_b), .out_if(if_b.master));

  // Observation view of the instance currently under test.
  int                cur;
  logic [DATA_W-1:0] o_data;
  logic [SEL_W-1:0]  o_idx;
  logic              o_valid, o_last, o_busy, o_done, o_err;
  always_comb begin
    if (cur == 0) begin
      o_data = if_a.Out_Data; o_idx = if_a.Out_Idx; o_valid = if_a.Out_Valid;
      o_last = if_a.Out_Last; o_busy = busy_a; o_done = done_a; o_err = err_a;
    end else begin
      o_data = if_b.Out_Data; o_idx = if_b.Out_Idx; o_valid = if_b.Out_Valid;
      o_last = if_b.Out_Last; o_busy = busy_b; o_done = done_b; o_err = err_b;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int scan_id  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    else n_pass++;
  endtask

  // Reference: the k-th word of a scan sits at (Base + k*Stride) mod N.
  function automatic int exp_idx(input int b, input int s, input int k, input int n);
    return (b + k * s) % n;
  endfunction

  task automatic set_ready(input int inst, input logic v);
    if (inst == 0) if_a.Out_Ready = v;
    else           if_b.Out_Ready = v;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " data"},  32'(o_data),  32'h0);
    check({tag, " idx"},   32'(o_idx),   32'h0);
    check({tag, " valid"}, 32'(o_valid), 32'h0);
    check({tag, " last"},  32'(o_last),  32'h0);
    check({tag, " busy"},  32'(o_busy),  32'h0);
    check({tag, " done"},  32'(o_done),  32'h0);
    check({tag, " err"},   32'(o_err),   32'h0);
  endtask

  task automatic idle_cycles(input int c, input bit poke_abort);
    for (int i = 0; i < c; i++) begin
      abort = poke_abort ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      abort = 1'b0;
      check($sformatf("s%0d idle done", scan_id), 32'(o_done),  32'h0);
      check($sformatf("s%0d idle err", scan_id),  32'(o_err),   32'h0);
      check($sformatf("s%0d idle valid", scan_id), 32'(o_valid), 32'h0);
      check($sformatf("s%0d idle busy", scan_id), 32'(o_busy),  32'h0);
    end
  endtask

  // One scan on instance inst, called at a negedge. rmode 1 = random ready and
  // stray Start pulses; the word at stall_k sees stall_n not-ready cycles, during
  // which the bank is scrambled when noise is set; abort_k aborts on that word.
  task automatic run_scan(input int inst, input int b, input int s, input int l,
                          input int rmode, input int stall_k, input int stall_n,
                          input int abort_k, input bit noise);
    int n, k, stalls, cyc;
    bit bad, r, do_abort;
    logic [DATA_W-1:0] cur_data;
    scan_id++;
    cur = inst;
    n   = (inst == 0) ? N_A : N_B;
    bad = (b >= n) || (s >= n) || (l > n);
    base = SEL_W'(b); stride = SEL_W'(s); len = (SEL_W+1)'(l);
    start[inst] = 1'b1;
    step();
    start[inst] = 1'b0;
    base = SEL_W'($urandom); stride = SEL_W'($urandom);
    if (bad || l == 0) begin
      check($sformatf("s%0d reject done", scan_id),  32'(o_done),  32'h1);
      check($sformatf("s%0d reject err", scan_id),   32'(o_err),   32'(bad));
      check($sformatf("s%0d reject valid", scan_id), 32'(o_valid), 32'h0);
      check($sformatf("s%0d reject busy", scan_id),  32'(o_busy),  32'h0);
      idle_cycles(1, 1'b0);
      return;
    end
    cur_data = tbl[b];
    k = 0; stalls = 0; cyc = 0;
    while (1) begin
      check($sformatf("s%0d k%0d idx", scan_id, k),   32'(o_idx),   32'(exp_idx(b, s, k, n)));
      check($sformatf("s%0d k%0d data", scan_id, k),  32'(o_data),  32'(cur_data));
      check($sformatf("s%0d k%0d valid", scan_id, k), 32'(o_valid), 32'h1);
      check($sformatf("s%0d k%0d last", scan_id, k),  32'(o_last),  32'(k == l - 1));
      check($sformatf("s%0d k%0d busy", scan_id, k),  32'(o_busy),  32'h1);
      check($sformatf("s%0d k%0d done", scan_id, k),  32'(o_done),  32'h0);
      do_abort = (k == abort_k);
      r = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (k == stall_k && stalls < stall_n) begin
        r = 1'b0;
        stalls++;
        if (noise) tbl[$urandom_range(0, N_A-1)] = DATA_W'($urandom);
      end
      if (rmode == 1 && $urandom_range(0, 3) == 0) start[inst] = 1'b1;
      set_ready(inst, r);
      abort = do_abort;
      step();
      abort = 1'b0;
      start[inst] = 1'b0;
      set_ready(inst, 1'b0);
      if (do_abort || (r && k == l - 1)) begin
        check($sformatf("s%0d end valid", scan_id), 32'(o_valid), 32'h0);
        check($sformatf("s%0d end last", scan_id),  32'(o_last),  32'h0);
        check($sformatf("s%0d end busy", scan_id),  32'(o_busy),  32'h0);
        check($sformatf("s%0d end done", scan_id),  32'(o_done),  32'h1);
        break;
      end
      if (r) begin
        k++;
        cur_data = tbl[exp_idx(b, s, k, n)];
      end
      cyc++;
      if (cyc > 8 * l + 40) begin
        check($sformatf("s%0d timeout", scan_id), 32'h1, 32'h0);
        break;
      end
    end
  endtask

  task automatic reset_table();
    for (int i = 0; i < N_A; i++) tbl[i] = DATA_W'(i + 'h100);
  endtask

  initial begin
    int inst, n, b, s, l, ak;
    reset_table();
    start = '0; base = '0; stride = '0; len = '0; abort = 1'b0;
    if_a.Out_Ready = 1'b0; if_b.Out_Ready = 1'b0;
    cur = 0;

    #1 rst_n = 1'b0;
    #2;
    cur = 0; check_zero("reset a");
    cur = 1; check_zero("reset b");
    #20 rst_n = 1'b1;
    @(negedge clk);

    // Wrapping scan 60,63,2,5,8 at full throughput, then Done seen only once.
    run_scan(0, 60, 3, 5, 0, -1, 0, -1, 1'b0);
    idle_cycles(1, 1'b0);

    // Second word (idx 63, 0x13F) held through three stalls while the bank changes.
    run_scan(0, 60, 3, 5, 0, 1, 3, -1, 1'b1);
    reset_table();
    idle_cycles(1, 1'b0);

    // Non-power-of-two bank: 40,2,12.
    run_scan(1, 40, 10, 3, 0, -1, 0, -1, 1'b0);
    idle_cycles(1, 1'b0);

    // Rejections: Base>=N_IN needs the 48-word instance (6-bit Base cannot hold 64).
    run_scan(1, 50, 1, 2, 0, -1, 0, -1, 1'b0);
    run_scan(1, 0, 48, 2, 0, -1, 0, -1, 1'b0);
    run_scan(0, 0, 1, 65, 0, -1, 0, -1, 1'b0);
    run_scan(0, 5, 1, 0, 0, -1, 0, -1, 1'b0);
    idle_cycles(3, 1'b1);

    // Abort together with a handshake on the 3rd word, then an immediate restart.
    run_scan(0, 10, 7, 6, 0, -1, 0, 2, 1'b0);
    run_scan(0, 5, 1, 3, 0, -1, 0, -1, 1'b0);
    idle_cycles(1, 1'b0);

    // Stride 0 repeats word[Base]; full-length scan on the 48-word instance.
    run_scan(0, 7, 0, 4, 0, -1, 0, -1, 1'b0);
    run_scan(1, 47, 47, 48, 1, -1, 0, -1, 1'b0);
    idle_cycles(1, 1'b0);

    for (int it = 0; it < 40; it++) begin
      inst = $urandom_range(0, 1);
      n = (inst == 0) ? N_A : N_B;
      b = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, n - 1);
      s = $urandom_range(0, n - 1);
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n + 1) : $urandom_range(0, 8);
      ak = ($urandom_range(0, 3) == 0 && l > 0) ? $urandom_range(0, l - 1) : -1;
      run_scan(inst, b, s, l, 1, $urandom_range(0, 3), $urandom_range(0, 3), ak,
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycles(1, 1'b1);
    end
    reset_table();

    // Asynchronous reset between edges in the middle of a scan.
    scan_id++;
    cur = 0;
    base = SEL_W'(20); stride = SEL_W'(1); len = (SEL_W+1)'(10);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    if_a.Out_Ready = 1'b1;
    step();
    step();
    check("pre-reset busy", 32'(o_busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    cur = 0; check_zero("mid reset a");
    cur = 1; check_zero("mid reset b");
    if_a.Out_Ready = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_scan(0, 20, 1, 4, 0, -1, 0, -1, 1'b0);
    idle_cycles(2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
